// File: rtl/dec_secded_pipe.sv
// Two-stage pipelined SECDED decoder with valid/ready handshake on both sides.
// Stage 1 registers the codeword, its mode and the H*c syndrome. Stage 2
// classifies the syndrome, corrects a single-bit error and drives the outputs.
// Saturating counters track corrected and uncorrectable words for link monitoring.
module dec_secded_pipe #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26,
    localparam int MAX_PARITY_WIDTH  = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH,
    localparam int H_WIDTH           = MAX_PARITY_WIDTH * MAX_CODEWORD_WIDTH,
    parameter logic [H_WIDTH-1:0] H_MODE0 =
        192'hFF_0000_00E4_0000_00D2_0000_00B1,
    parameter logic [H_WIDTH-1:0] H_MODE1 =
        192'hFFFF_0000_FE08_0000_F1C4_0000_CDA2_0000_AB61,
    parameter logic [H_WIDTH-1:0] H_MODE2 =
        192'hFFFF_FFFF_FFFE_0010_FF01_FC08_F0F1_E384_CCCD_9B42_AAAB_56C1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
    input  logic [1:0]                    work_mod,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
    output logic [MAX_PARITY_WIDTH-1:0]   syndrome_out,
    output logic                          err_single,
    output logic                          err_double,
    output logic                          mode_err,
    input  logic                          cnt_clr,
    output logic [CNT_WIDTH-1:0]          cnt_single,
    output logic [CNT_WIDTH-1:0]          cnt_double
);

    localparam int CW = MAX_CODEWORD_WIDTH;
    localparam int PW = MAX_PARITY_WIDTH;

    // Row index of the overall-parity row for each legal mode.
    localparam int PAR_ROW0 = 3;
    localparam int PAR_ROW1 = 4;
    localparam int PAR_ROW2 = 5;

    // H matrix for a mode; the illegal mode maps to all-zero so its syndrome is zero.
    function automatic logic [H_WIDTH-1:0] h_select(input logic [1:0] mode);
        case (mode)
            2'b00:   return H_MODE0;
            2'b01:   return H_MODE1;
            2'b10:   return H_MODE2;
            default: return '0;
        endcase
    endfunction

    // Syndrome bit k is the parity of row k masked by the codeword.
    function automatic logic [PW-1:0] calc_syndrome(input logic [H_WIDTH-1:0] h,
                                                    input logic [CW-1:0] c);
        logic [PW-1:0] s;
        s = '0;
        for (int k = 0; k < PW; k++) begin
            s[k] = ^(h[k*CW +: CW] & c);
        end
        return s;
    endfunction

    // Column j of H gathered across all rows.
    function automatic logic [PW-1:0] h_column(input logic [H_WIDTH-1:0] h,
                                               input int j);
        logic [PW-1:0] col;
        col = '0;
        for (int k = 0; k < PW; k++) begin
            col[k] = h[k*CW + j];
        end
        return col;
    endfunction

    // Overall-parity bit of a syndrome for the given mode.
    function automatic logic parity_bit(input logic [1:0] mode,
                                        input logic [PW-1:0] s);
        case (mode)
            2'b00:   return s[PAR_ROW0];
            2'b01:   return s[PAR_ROW1];
            2'b10:   return s[PAR_ROW2];
            default: return 1'b0;
        endcase
    endfunction

    // Saturating increment: all-ones sticks.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) return v;
        return v + CNT_WIDTH'(1);
    endfunction

    logic                 advance;
    logic [PW-1:0]        syn_in;

    logic                 vld_p1;
    logic [CW-1:0]        data_p1;
    logic [1:0]           mode_p1;
    logic [PW-1:0]        syn_p1;

    logic [CW-1:0]        data_fix;
    logic [PW-1:0]        syn_fix;
    logic                 single_fix;
    logic                 double_fix;
    logic                 mode_fix;
    logic                 out_fire;

    // Whole pipeline moves together; it only stops when a held output is not taken.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign out_fire = out_valid && out_ready;

    assign syn_in = calc_syndrome(h_select(work_mod), data_in);

    // ---- stage 1: capture word, mode and syndrome ----
    // Stage-1 valid bit; carries bubbles forward.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (advance) begin
            vld_p1 <= in_valid;
        end
    end

    // Stage-1 data registers; loaded only for an accepted word.
    always_ff @(posedge clk) begin
        if (advance && in_valid) begin
            data_p1 <= data_in;
            mode_p1 <= work_mod;
            syn_p1  <= syn_in;
        end
    end

    // ---- stage 2: classify and correct ----
    // Syndrome decode: find the matching H column and build the corrected word.
    always_comb begin
        logic [H_WIDTH-1:0] h;
        logic               found;
        logic [CW-1:0]      mask;
        h          = h_select(mode_p1);
        found      = 1'b0;
        mask       = '0;
        data_fix   = data_p1;
        syn_fix    = syn_p1;
        single_fix = 1'b0;
        double_fix = 1'b0;
        mode_fix   = 1'b0;
        for (int j = 0; j < CW; j++) begin
            if (!found && h_column(h, j) == syn_p1) begin
                found   = 1'b1;
                mask[j] = 1'b1;
            end
        end
        if (mode_p1 == 2'b11) begin
            mode_fix = 1'b1;
            syn_fix  = '0;
        end else if (syn_p1 != '0) begin
            if (parity_bit(mode_p1, syn_p1) && found) begin
                single_fix = 1'b1;
                data_fix   = data_p1 ^ mask;
            end else begin
                double_fix = 1'b1;
            end
        end
    end

    // Output register; holds stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            data_out     <= '0;
            syndrome_out <= '0;
            err_single   <= 1'b0;
            err_double   <= 1'b0;
            mode_err     <= 1'b0;
        end else if (advance) begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                data_out     <= data_fix;
                syndrome_out <= syn_fix;
                err_single   <= single_fix;
                err_double   <= double_fix;
                mode_err     <= mode_fix;
            end
        end
    end

    // Error-event counters; count on output handshake, clear has priority.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_single <= '0;
            cnt_double <= '0;
        end else if (out_fire) begin
            if (err_single) cnt_single <= sat_inc(cnt_single);
            if (err_double) cnt_double <= sat_inc(cnt_double);
        end
    end

endmodule

// File: tb/tb_dec_secded_pipe.sv
// Directed bench for dec_secded_pipe: hand-computed vectors for each mode,
// back-pressure ordering, illegal mode, counter saturation/clear, mid-stream reset.
module tb_dec_secded_pipe;

    localparam int CW = 32;
    localparam int PW = 6;
    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [CW-1:0]   data_in;
    logic [1:0]      work_mod;
    logic            out_valid;
    logic            out_ready;
    logic [CW-1:0]   data_out;
    logic [PW-1:0]   syndrome_out;
    logic            err_single;
    logic            err_double;
    logic            mode_err;
    logic            cnt_clr;
    logic [CNTW-1:0] cnt_single;
    logic [CNTW-1:0] cnt_double;

    int checks   = 0;
    int failures = 0;

    dec_secded_pipe #(.CNT_WIDTH(CNTW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_in      (data_in),
        .work_mod     (work_mod),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_out     (data_out),
        .syndrome_out (syndrome_out),
        .err_single   (err_single),
        .err_double   (err_double),
        .mode_err     (mode_err),
        .cnt_clr      (cnt_clr),
        .cnt_single   (cnt_single),
        .cnt_double   (cnt_double)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [CW-1:0] d, input logic [1:0] m);
        in_valid = 1'b1;
        data_in  = d;
        work_mod = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        data_in  = '0;
        work_mod = 2'b00;
    endtask

    // Send one word into an idle pipe, then check the output one edge later.
    task automatic word(input string tag, input logic [CW-1:0] d, input logic [1:0] m,
                        input logic [CW-1:0] ed, input logic [PW-1:0] es,
                        input logic fs, input logic fd, input logic fm);
        send(d, m);
        @(posedge clk); #1;
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, data_out, ed);
        chk({tag, "_syn"}, 32'(syndrome_out), 32'(es));
        chk({tag, "_flags"}, {29'd0, err_single, err_double, mode_err}, {29'd0, fs, fd, fm});
        @(posedge clk); #1;
    endtask

    // Back-pressure stream: words and their hand-derived results.
    logic [CW-1:0] bp_din  [4] = '{32'h30, 32'h0003, 32'h10, 32'h0001};
    logic [1:0]    bp_mode [4] = '{2'b00, 2'b01, 2'b00, 2'b01};
    logic [CW-1:0] bp_dout [4] = '{32'h30, 32'h0003, 32'h00, 32'h0000};
    logic [PW-1:0] bp_syn  [4] = '{6'h06, 6'h03, 6'h0B, 6'h11};
    logic [2:0]    bp_flg  [4] = '{3'b010, 3'b010, 3'b100, 3'b100};

    initial begin
        int pi, ci;
        logic accepted, prev_stall;
        logic [CW-1:0] prev_d;
        logic [PW-1:0] prev_s;

        rst = 1'b1; in_valid = 1'b0; data_in = '0; work_mod = 2'b00;
        out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_syn", 32'(syndrome_out), 32'd0);
        chk("rst_flags", {29'd0, err_single, err_double, mode_err}, 32'd0);
        chk("rst_cnts", {24'd0, cnt_single, cnt_double}, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        word("m0_clean", 32'h00, 2'b00, 32'h00, 6'h0, 1'b0, 1'b0, 1'b0);
        word("m0_single", 32'h10, 2'b00, 32'h00, 6'hB, 1'b1, 1'b0, 1'b0);
        chk("cnt_single_1", 32'(cnt_single), 32'd1);
        word("m0_double", 32'h30, 2'b00, 32'h30, 6'h6, 1'b0, 1'b1, 1'b0);
        chk("cnt_double_1", 32'(cnt_double), 32'd1);
        word("m1_single", 32'h0001, 2'b01, 32'h0000, 6'h11, 1'b1, 1'b0, 1'b0);
        word("m2_single", 32'h0000_0001, 2'b10, 32'h0, 6'h21, 1'b1, 1'b0, 1'b0);
        chk("cnt_single_3", 32'(cnt_single), 32'd3);
        word("mode_ill", 32'h1234, 2'b11, 32'h1234, 6'h0, 1'b0, 1'b0, 1'b1);
        chk("mode_ill_cnts", {24'd0, cnt_single, cnt_double}, {24'd0, 4'd3, 4'd1});

        // Back-pressure: output stalled for three cycles while words queue up.
        pi = 0; ci = 0; prev_stall = 1'b0; prev_d = '0; prev_s = '0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            in_valid  = (pi < 4);
            data_in   = (pi < 4) ? bp_din[pi] : '0;
            work_mod  = (pi < 4) ? bp_mode[pi] : 2'b00;
            out_ready = !(cyc >= 2 && cyc < 5);
            @(negedge clk);
            if (prev_stall) begin
                chk("bp_hold_data", data_out, prev_d);
                chk("bp_hold_syn", 32'(syndrome_out), 32'(prev_s));
            end
            if (out_valid && !out_ready) chk("bp_in_ready", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (ci < 4) begin
                    chk("bp_data", data_out, bp_dout[ci]);
                    chk("bp_syn", 32'(syndrome_out), 32'(bp_syn[ci]));
                    chk("bp_flags", {29'd0, err_single, err_double, mode_err}, {29'd0, bp_flg[ci]});
                end
                ci++;
            end
            accepted   = in_valid && in_ready;
            prev_stall = out_valid && !out_ready;
            prev_d     = data_out;
            prev_s     = syndrome_out;
            @(posedge clk); #1;
            if (accepted) pi++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_out_count", 32'(ci), 32'd4);
        chk("bp_cnt_single", 32'(cnt_single), 32'd5);
        chk("bp_cnt_double", 32'(cnt_double), 32'd3);

        // Fill cnt_single to all-ones, then one more single error must not wrap.
        in_valid = 1'b1; data_in = 32'h10; work_mod = 2'b00;
        repeat (10) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("cnt_at_max", 32'(cnt_single), 32'd15);
        send(32'h10, 2'b00);
        repeat (3) @(posedge clk);
        #1 chk("cnt_saturated", 32'(cnt_single), 32'd15);

        // Clear coincides with a flagged-word handshake: clear wins.
        send(32'h10, 2'b00);
        @(posedge clk); #1;
        chk("clr_pre_vld", 32'(out_valid && err_single), 32'd1);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("clr_single", 32'(cnt_single), 32'd0);
        chk("clr_double", 32'(cnt_double), 32'd0);

        // Reset with a word in flight: it must never appear.
        send(32'h10, 2'b00);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_vld0", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk("midrst_vld1", 32'(out_valid), 32'd0);
        chk("midrst_data", data_out, 32'd0);
        chk("midrst_cnt", 32'(cnt_single), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
